// File: rtl/nou_rpu_rx.sv
`timescale 1ns/1ps
// nou_rpu_rx: inbound packet receiver on the destination tile.
// Accepts a head flit followed by N data flits from the NoC data channel.
// Payload flits are forwarded to the local write path through a 2-entry skid buffer.
// A head-ack and a data-ack are returned on the NoC response channel.
module nou_rpu_rx #(
  parameter int unsigned DW     = 512,
  parameter int unsigned TIDW   = 8,
  parameter int unsigned RSPW   = 32,
  parameter int unsigned TO_CYC = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [9:0]       local_tile_id,
  input  logic             noc_rpu_data_vld,
  output logic             rpu_noc_data_rdy,
  input  logic [TIDW-1:0]  noc_rpu_data_tid,
  input  logic [1:0]       noc_rpu_data_type,
  input  logic [DW-1:0]    noc_rpu_data,
  output logic             rpu_noc_rsp_vld,
  input  logic             noc_rpu_rsp_rdy,
  output logic [TIDW-1:0]  rpu_noc_rsp_tid,
  output logic [1:0]       rpu_noc_rsp_type,
  output logic [RSPW-1:0]  rpu_noc_rsp,
  output logic             rpu_wr_vld,
  input  logic             wr_rpu_rdy,
  output logic [DW-1:0]    rpu_wr_data,
  output logic             rpu_wr_last,
  output logic [31:0]      rpu_wr_pkt_id,
  output logic [9:0]       rpu_wr_src_tile,
  output logic             rpu_busy
);

  localparam int unsigned TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TO_CYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HRSP = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DRSP = 2'd3;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;

  localparam logic [7:0] ERR_OK   = 8'h00;
  localparam logic [7:0] ERR_DST  = 8'h01;
  localparam logic [7:0] ERR_N0   = 8'h02;
  localparam logic [7:0] ERR_TYPE = 8'h03;
  localparam logic [7:0] ERR_TO   = 8'h04;

  logic [1:0]      r_state;
  logic [TIDW-1:0] r_tid;
  logic [9:0]      r_src;
  logic [31:0]     r_pkt_id;
  logic [11:0]     r_cnt;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_err;
  logic            r_rsp_vld;
  logic [1:0]      r_rsp_type;

  logic [DW-1:0]   r_buf_data [2];
  logic [1:0]      r_buf_last;
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_fcnt;

  logic [9:0]      w_hd_dst;
  logic [9:0]      w_hd_src;
  logic [11:0]     w_hd_cnt;
  logic [31:0]     w_hd_pkt_id;
  logic [7:0]      w_hd_err;
  logic            w_buf_full;
  logic            w_acc;
  logic            w_is_head;
  logic            w_is_data;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_fcnt_nxt;
  logic            w_rsp_hs;
  logic [TW-1:0]   w_timer_inc;
  logic            w_timeout;

  assign w_hd_dst    = noc_rpu_data[9:0];
  assign w_hd_src    = noc_rpu_data[19:10];
  assign w_hd_cnt    = noc_rpu_data[31:20];
  assign w_hd_pkt_id = noc_rpu_data[95:64];

  assign w_buf_full  = (r_fcnt == 2'd2);
  assign w_is_head   = (noc_rpu_data_type == T_HEAD);
  assign w_is_data   = (noc_rpu_data_type == T_DATA);
  assign w_acc       = noc_rpu_data_vld && rpu_noc_data_rdy;
  assign w_push      = (r_state == S_DATA) && w_acc && w_is_data;
  assign w_pop       = (r_fcnt != 2'd0) && wr_rpu_rdy;
  assign w_fcnt_nxt  = r_fcnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_rsp_hs    = r_rsp_vld && noc_rpu_rsp_rdy;
  assign w_timer_inc = r_timer + TW'(1);
  assign w_timeout   = (r_state == S_DATA) && !w_acc && (w_timer_inc == TO_LIM);

  // Head check: destination mismatch takes priority over an empty packet.
  always_comb begin
    w_hd_err = ERR_OK;
    if (w_hd_dst != local_tile_id) begin
      w_hd_err = ERR_DST;
    end else if (w_hd_cnt == 12'd0) begin
      w_hd_err = ERR_N0;
    end
  end

  // Inbound ready: always open in IDLE, open while the skid buffer has room in DATA.
  always_comb begin
    rpu_noc_data_rdy = 1'b0;
    case (r_state)
      S_IDLE:  rpu_noc_data_rdy = 1'b1;
      S_DATA:  rpu_noc_data_rdy = !w_buf_full;
      default: rpu_noc_data_rdy = 1'b0;
    endcase
  end

  // Packet sequencing, head latching, flit counting, idle timer and response generation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_tid      <= '0;
      r_src      <= '0;
      r_pkt_id   <= '0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_err      <= ERR_OK;
      r_rsp_vld  <= 1'b0;
      r_rsp_type <= T_HEAD;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_is_head) begin
            r_tid      <= noc_rpu_data_tid;
            r_src      <= w_hd_src;
            r_pkt_id   <= w_hd_pkt_id;
            r_cnt      <= w_hd_cnt;
            r_err      <= w_hd_err;
            r_rsp_vld  <= 1'b1;
            r_rsp_type <= T_HEAD;
            r_state    <= S_HRSP;
          end
        end
        S_HRSP: begin
          if (w_rsp_hs) begin
            r_rsp_vld <= 1'b0;
            r_timer   <= '0;
            r_state   <= (r_err == ERR_OK) ? S_DATA : S_IDLE;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_timer <= '0;
            if (w_is_data) begin
              r_cnt <= r_cnt - 12'd1;
              if (r_cnt == 12'd1) begin
                r_state <= S_DRSP;
              end
            end else begin
              r_err   <= ERR_TYPE;
              r_state <= S_DRSP;
            end
          end else if (w_timeout) begin
            r_err   <= ERR_TO;
            r_state <= S_DRSP;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: begin
          // Raise data-ack on the same edge that empties the buffer so it follows the last pop by one cycle.
          if (!r_rsp_vld && (w_fcnt_nxt == 2'd0)) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_type <= T_DATA;
          end else if (w_rsp_hs) begin
            r_rsp_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_fcnt     <= 2'd0;
      r_buf_last <= '0;
    end else begin
      if (w_push) begin
        r_wptr             <= !r_wptr;
        r_buf_last[r_wptr] <= (r_cnt == 12'd1);
      end
      if (w_pop) begin
        r_rptr <= !r_rptr;
      end
      r_fcnt <= w_fcnt_nxt;
    end
  end

  // Skid buffer payload storage; contents are qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wptr] <= noc_rpu_data;
    end
  end

  assign rpu_wr_vld       = (r_fcnt != 2'd0);
  assign rpu_wr_data      = r_buf_data[r_rptr];
  assign rpu_wr_last      = r_buf_last[r_rptr];
  assign rpu_wr_pkt_id    = r_pkt_id;
  assign rpu_wr_src_tile  = r_src;

  assign rpu_noc_rsp_vld  = r_rsp_vld;
  assign rpu_noc_rsp_tid  = r_tid;
  assign rpu_noc_rsp_type = r_rsp_type;
  assign rpu_noc_rsp      = RSPW'({r_err, (r_err == ERR_OK), local_tile_id});

  assign rpu_busy         = (r_state != S_IDLE);

endmodule

// File: doc/nou_rpu_rx.md
Name: nou_rpu_rx

Overview:
- Inbound packet receiver on the destination tile.
- Consumes the head flit plus data flits that the send-side packet unit emits on the NoC data channel.
- Checks the head flit and counts data flits, then forwards payload flits to the local write path through a 2-entry skid buffer.
- Returns a head-ack and a data-ack on the NoC response channel, whose rsp word is laid out as consumed by the send-side response checker.

Parameters:
- DW, 512, NoC data flit width.
- TIDW, 8, transaction-id width.
- RSPW, 32, NoC response word width.
- TO_CYC, 4096, max idle cycles between consecutive data flits before timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- local_tile_id  in  10  this tile's id, quasi-static
- noc_rpu_data_vld  in  1  inbound flit valid
- rpu_noc_data_rdy  out  1  inbound flit ready
- noc_rpu_data_tid  in  TIDW  transaction id
- noc_rpu_data_type  in  2  2'b00 head, 2'b01 data; other values illegal
- noc_rpu_data  in  DW  flit payload
- rpu_noc_rsp_vld  out  1  response valid
- noc_rpu_rsp_rdy  in  1  response ready
- rpu_noc_rsp_tid  out  TIDW  tid latched from the head flit
- rpu_noc_rsp_type  out  2  2'b00 head-ack, 2'b01 data-ack
- rpu_noc_rsp  out  RSPW  [9:0] local tile id, [10] status (1=ok), [18:11] err code, rest 0
- rpu_wr_vld  out  1  payload flit valid to local write path
- wr_rpu_rdy  in  1  write path ready
- rpu_wr_data  out  DW  payload flit
- rpu_wr_last  out  1  last payload flit of packet
- rpu_wr_pkt_id  out  32  pkt_id of current packet
- rpu_wr_src_tile  out  10  source tile of current packet
- rpu_busy  out  1  state != IDLE

Behaviour:
- Reset: rstn sampled only at posedge clk.
  - All valid outputs, rpu_busy, counters, timer and buffer pointers clear to 0; state = IDLE.
  - Reset mid-packet discards everything and emits no response.
- Head flit decode:
  - [9:0] dst tile, [19:10] src tile, [31:20] flit count N, [39:32] header sz, [45:40] data sz, [95:64] pkt_id.
  - Latch tid, src tile and pkt_id on head accept.
- Error codes: 0x00 ok, 0x01 dst tile mismatch, 0x02 N==0, 0x03 unexpected flit type, 0x04 inter-flit timeout.
- IDLE:
  - rdy=1.
  - Head flit accepted -> HRSP, with ok/err computed the same cycle.
  - A data or illegal flit in IDLE is accepted and dropped silently; no response.
- HRSP:
  - rdy=0; assert head-ack until rsp_rdy.
  - Status 0 -> IDLE after handshake.
  - Status 1 -> DATA with remaining count = N, timer = 0.
- DATA:
  - rdy = buffer not full.
  - Each accepted data flit is pushed to the skid buffer and decrements the count; last = (count==1).
  - Push of the last flit -> DRSP.
  - A head flit in DATA is accepted and dropped, err 0x03 -> DRSP.
  - Timer counts cycles with no accepted flit and resets on accept; reaching TO_CYC gives err 0x04 -> DRSP.
- DRSP:
  - rdy=0; waits until the skid buffer is empty.
  - Then asserts data-ack (status = no error recorded) until rsp_rdy -> IDLE.
- Skid buffer:
  - 2 entries holding {data, last}.
  - Push and pop in the same cycle are allowed; no bubble at full throughput.
  - rpu_wr_vld = not empty; outputs held stable while vld && !rdy.
- Errored packets:
  - Flits already pushed are still delivered.
  - Last is not forced on error; the write path relies on the data-ack status.
- rsp outputs are stable while vld && !rdy; tid is always the latched head tid.
- Latency:
  - Head accept to head-ack vld: 1 cycle.
  - Flit accept to rpu_wr_vld: 1 cycle.
  - Last pop to data-ack vld: 1 cycle.
- Counter width 12 bits; N=4095 is legal. Timer width clog2(TO_CYC+1).

Test Plan:
- Head with dst=local, N=3, pkt_id=0xA5A5_0001; 3 data flits; wr_rdy=1 -> head-ack rsp=0x0000_0400|local; 3 wr beats, last on beat 3 with pkt_id 0xA5A5_0001; then data-ack status=1, err=0.
- Head with dst != local -> head-ack status=0, err=0x01; following data flits dropped; no wr beats; no data-ack.
- N=2, wr_rdy held 0 for 10 cycles -> rpu_noc_data_rdy drops after 2 buffered flits, no loss, data stable; release gives 2 beats in order, last on beat 2.
- N=5, stop sending after 2 flits -> after TO_CYC idle cycles, data-ack status=0, err=0x04; exactly 2 wr beats, neither marked last.
- Head flit arrives in DATA with 1 flit remaining -> data-ack err=0x03, state returns to IDLE.
- rstn asserted mid-DATA with rsp_rdy=0 -> next cycle all vld=0, rpu_busy=0; a fresh packet afterwards completes normally.
